// File: rtl/bcd_disp_pkg.sv
// Shared types, segment constants and small helpers for the BCD display scanner.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;        // {g,f,e,d,c,b,a}, active-high
    typedef logic [3:0] bcd_digit_t;  // one packed BCD nibble
    typedef logic [1:0] digit_idx_t;  // which of the four digits is being scanned

    localparam int unsigned NUM_DIGITS = 4;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= 4'd9);
    endfunction

    // One-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD to 7-segment decoder with blanking; non-BCD nibbles show a dash.
module bcd_seg_decoder
    import bcd_disp_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    output seg_t       seg
);

    // Blank overrides the digit; codes A-F fall through to the dash.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit 7-segment driver. The BCD input is latched once per
// scan frame so a frame never mixes digits from two different counts.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned PW_RAW = $clog2(CLK_DIV + 1);
    localparam int unsigned PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    logic [15:0]   snap;

    logic          tick;
    logic          frame_end;
    logic          load_bad;
    bcd_digit_t    cur_digit;
    logic [3:1]    upper_zero;
    logic          cur_blank;
    seg_t          seg_next;

    // Dwell tick and end-of-frame condition.
    always_comb begin
        tick      = (presc == PMAX);
        frame_end = tick && (idx == 2'd3);
    end

    // Any nibble of the value about to be latched that is not a decimal digit.
    always_comb begin
        load_bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(bcd_in[4*i +: 4])) begin
                load_bad = 1'b1;
            end
        end
    end

    // Select the snapshot nibble for the digit currently being scanned.
    always_comb begin
        cur_digit = snap[{idx, 2'b00} +: 4];
    end

    // upper_zero[i]: nibbles i..3 of the snapshot are all zero (A-F counts as non-zero).
    always_comb begin
        upper_zero[3] = (snap[15:12] == 4'd0);
        upper_zero[2] = upper_zero[3] && (snap[11:8] == 4'd0);
        upper_zero[1] = upper_zero[2] && (snap[7:4] == 4'd0);
    end

    // Leading-zero blanking for digits 1..3; digit 0 always shows.
    always_comb begin
        cur_blank = 1'b0;
        if (BLANK_LEADING) begin
            case (idx)
                2'd1:    cur_blank = upper_zero[1];
                2'd2:    cur_blank = upper_zero[2];
                2'd3:    cur_blank = upper_zero[3];
                default: cur_blank = 1'b0;
            endcase
        end
    end

    bcd_seg_decoder u_dec (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    // Prescaler and digit index; the index advances once per dwell period.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Frame snapshot, frame-wrap pulse and sticky non-BCD flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                snap <= bcd_in;
                if (load_bad) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Registered display outputs, one cycle behind the index and snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '0;
            seg <= SEG_BLANK;
        end else begin
            an  <= digit_onehot(idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: three instances cover CLK_DIV=4 with and
// without leading-zero blanking, and CLK_DIV=1.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = 16'h0000;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic [3:0]  an_a, an_b, an_c;
    logic        fd_a, fd_b, fd_c;
    logic        err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.CLK_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
        .clk(clk), .reset(reset), .bcd_in(bcd_in),
        .seg(seg_a), .an(an_a), .frame_done(fd_a), .err(err_a)
    );

    bcd_display_scanner #(.CLK_DIV(4), .BLANK_LEADING(1'b0)) u_nb (
        .clk(clk), .reset(reset), .bcd_in(bcd_in),
        .seg(seg_b), .an(an_b), .frame_done(fd_b), .err(err_b)
    );

    bcd_display_scanner #(.CLK_DIV(1), .BLANK_LEADING(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .bcd_in(bcd_in),
        .seg(seg_c), .an(an_c), .frame_done(fd_c), .err(err_c)
    );

    // Expected anode for sample j after reset release with CLK_DIV = 4.
    function automatic logic [3:0] exp_an4(input int j);
        return 4'b0001 << ((j / 4) % 4);
    endfunction

    // Holds reset two cycles, releases it; returns at the first sample after release.
    task automatic release_reset(input logic [15:0] val);
        @(negedge clk);
        reset  = 1'b1;
        bcd_in = val;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({an_a, seg_a, fd_a, err_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_a: got an=%b seg=%h fd=%b err=%b want all 0", an_a, seg_a, fd_a, err_a);
        end
        checks++;
        if ({an_b, seg_b, fd_b, err_b} !== 13'd0) begin
            errors++;
            $display("FAIL reset_b: got an=%b seg=%h fd=%b err=%b want all 0", an_b, seg_b, fd_b, err_b);
        end
        checks++;
        if ({an_c, seg_c, fd_c, err_c} !== 13'd0) begin
            errors++;
            $display("FAIL reset_c: got an=%b seg=%h fd=%b err=%b want all 0", an_c, seg_c, fd_c, err_c);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({an_a, seg_a} !== {4'b0001, 7'h3F}) begin
            errors++;
            $display("FAIL first_a: got an=%b seg=%h want 0001 3f", an_a, seg_a);
        end
        checks++;
        if ({an_b, seg_b} !== {4'b0001, 7'h3F}) begin
            errors++;
            $display("FAIL first_b: got an=%b seg=%h want 0001 3f", an_b, seg_b);
        end
        checks++;
        if ({an_c, seg_c} !== {4'b0001, 7'h3F}) begin
            errors++;
            $display("FAIL first_c: got an=%b seg=%h want 0001 3f", an_c, seg_c);
        end
    endtask

    task automatic test_frame();
        logic [6:0] f2 [4];
        logic [6:0] es;
        int d;
        f2 = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        release_reset(16'h1234);
        for (int j = 0; j < 32; j++) begin
            d  = (j / 4) % 4;
            es = (j < 16) ? ((d == 0) ? 7'h3F : 7'h00) : f2[d];
            checks++;
            if (an_a !== exp_an4(j)) begin
                errors++;
                $display("FAIL frame_an j=%0d: got %b want %b", j, an_a, exp_an4(j));
            end
            checks++;
            if (seg_a !== es) begin
                errors++;
                $display("FAIL frame_seg j=%0d: got %h want %h", j, seg_a, es);
            end
            checks++;
            if (fd_a !== ((j % 16) == 15)) begin
                errors++;
                $display("FAIL frame_fd j=%0d: got %b want %b", j, fd_a, ((j % 16) == 15));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        logic [6:0] fa [4];
        logic [6:0] fb [4];
        logic [6:0] ea, eb;
        int d;
        fa = '{7'h3F, 7'h07, 7'h00, 7'h00};
        fb = '{7'h3F, 7'h07, 7'h3F, 7'h3F};
        release_reset(16'h0070);
        for (int j = 0; j < 32; j++) begin
            d  = (j / 4) % 4;
            ea = (j < 16) ? ((d == 0) ? 7'h3F : 7'h00) : fa[d];
            eb = (j < 16) ? 7'h3F : fb[d];
            checks++;
            if (seg_a !== ea) begin
                errors++;
                $display("FAIL blank_on j=%0d: got %h want %h", j, seg_a, ea);
            end
            checks++;
            if (seg_b !== eb) begin
                errors++;
                $display("FAIL blank_off j=%0d: got %h want %h", j, seg_b, eb);
            end
            checks++;
            if (an_b !== exp_an4(j)) begin
                errors++;
                $display("FAIL blank_off_an j=%0d: got %b want %b", j, an_b, exp_an4(j));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_error();
        logic [6:0] f2 [4];
        logic [6:0] f3 [4];
        logic [6:0] es;
        int d;
        f2 = '{7'h6D, 7'h40, 7'h00, 7'h00};
        f3 = '{7'h6D, 7'h00, 7'h00, 7'h00};
        release_reset(16'h00A5);
        for (int j = 0; j < 48; j++) begin
            d = (j / 4) % 4;
            if (j < 16)      es = (d == 0) ? 7'h3F : 7'h00;
            else if (j < 32) es = f2[d];
            else             es = f3[d];
            checks++;
            if (seg_a !== es) begin
                errors++;
                $display("FAIL err_seg j=%0d: got %h want %h", j, seg_a, es);
            end
            checks++;
            if (err_a !== (j >= 15)) begin
                errors++;
                $display("FAIL err_flag j=%0d: got %b want %b", j, err_a, (j >= 15));
            end
            if (j == 20) bcd_in = 16'h0005;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", err_a);
        end
        reset = 1'b0;
    endtask

    task automatic test_tearing();
        logic [6:0] es;
        int d;
        release_reset(16'h1111);
        for (int j = 0; j < 48; j++) begin
            d = (j / 4) % 4;
            if (j < 16)      es = (d == 0) ? 7'h3F : 7'h00;
            else if (j < 32) es = 7'h06;
            else             es = 7'h5B;
            checks++;
            if (seg_a !== es) begin
                errors++;
                $display("FAIL tear_seg j=%0d: got %h want %h", j, seg_a, es);
            end
            if (j == 20) bcd_in = 16'h2222;
            @(negedge clk);
        end
    endtask

    task automatic test_frame_done();
        int last_a = -1, last_c = -1;
        int cnt_a = 0, cnt_c = 0;
        logic prev_a = 1'b0, prev_c = 1'b0;
        for (int j = 0; j < 64; j++) begin
            if (fd_a === 1'b1) begin
                cnt_a++;
                checks++;
                if (prev_a !== 1'b0) begin
                    errors++;
                    $display("FAIL fd4_width j=%0d: got prev %b want 0", j, prev_a);
                end
                if (last_a >= 0) begin
                    checks++;
                    if (j - last_a != 16) begin
                        errors++;
                        $display("FAIL fd4_gap j=%0d: got %0d want 16", j, j - last_a);
                    end
                end
                last_a = j;
            end
            if (fd_c === 1'b1) begin
                cnt_c++;
                checks++;
                if (prev_c !== 1'b0) begin
                    errors++;
                    $display("FAIL fd1_width j=%0d: got prev %b want 0", j, prev_c);
                end
                if (last_c >= 0) begin
                    checks++;
                    if (j - last_c != 4) begin
                        errors++;
                        $display("FAIL fd1_gap j=%0d: got %0d want 4", j, j - last_c);
                    end
                end
                last_c = j;
            end
            prev_a = fd_a;
            prev_c = fd_c;
            @(negedge clk);
        end
        checks++;
        if (cnt_a != 4) begin
            errors++;
            $display("FAIL fd4_count: got %0d want 4", cnt_a);
        end
        checks++;
        if (cnt_c != 16) begin
            errors++;
            $display("FAIL fd1_count: got %0d want 16", cnt_c);
        end
    endtask

    task automatic test_midreset();
        logic [3:0] ea;
        logic [6:0] es;
        release_reset(16'h1234);
        for (int j = 0; j < 24; j++) @(negedge clk);
        checks++;
        if ({an_a, seg_a} !== {4'b0100, 7'h5B}) begin
            errors++;
            $display("FAIL mid_pre: got an=%b seg=%h want 0100 5b", an_a, seg_a);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({an_a, seg_a, fd_a, err_a} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset: got an=%b seg=%h fd=%b err=%b want all 0", an_a, seg_a, fd_a, err_a);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            ea = (j < 4) ? 4'b0001 : 4'b0010;
            es = (j < 4) ? 7'h3F : 7'h00;
            checks++;
            if ({an_a, seg_a} !== {ea, es}) begin
                errors++;
                $display("FAIL mid_restart j=%0d: got an=%b seg=%h want %b %h", j, an_a, seg_a, ea, es);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_blanking();
        test_error();
        test_tearing();
        test_frame_done();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
